// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- hazard-detect inputs and pipeline-steering outputs shared
// between the pipeline controller and the datapath.
//   id_rs1/id_rs2, id_use1/id_use2 : source regs of the instruction in IF/ID
//   ex_rd, ex_wen                  : destination of the instruction in EX
//   pc_en, ifid_en, ifid_flush     : PC advance, IF/ID load, IF/ID clear
//   ex_bubble                      : NOP insertion into EX
// master = controller side, slave = datapath side.
interface pipe_ctrl_if #(
   parameter int RAW = 5
);
   logic [RAW-1:0] id_rs1;
   logic [RAW-1:0] id_rs2;
   logic           id_use1;
   logic           id_use2;
   logic [RAW-1:0] ex_rd;
   logic           ex_wen;
   logic           pc_en;
   logic           ifid_en;
   logic           ifid_flush;
   logic           ex_bubble;

   modport master (
      input  id_rs1, id_rs2, id_use1, id_use2, ex_rd, ex_wen,
      output pc_en, ifid_en, ifid_flush, ex_bubble
   );

   modport slave (
      output id_rs1, id_rs2, id_use1, id_use2, ex_rd, ex_wen,
      input  pc_en, ifid_en, ifid_flush, ex_bubble
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- in-order pipeline controller: RAW-hazard stall, orderly
// drain-to-halt and active/stall performance counters.
// Ports:
//   clk, rst (async, active-low)
//   start     : launch/relaunch from IDLE or HALT
//   halt_req  : orderly stop (wins over hazard and over start)
//   step      : single-step in HALT, only when PIPE_CTRL_STEP_EN is defined
//   bus       : pipe_ctrl_if.master (hazard inputs, steering outputs)
//   busy, halted, cycle_cnt, stall_cnt : status and counters
// Optional feature macro: PIPE_CTRL_STEP_EN (adds the step input).
// Steering outputs are combinational so a hazard bubbles EX in the same cycle.
module pipe_ctrl #(
   parameter int RAW       = 5,
   parameter int CW        = 16,
   parameter int STALL_CYC = 2,
   parameter int DRAIN_CYC = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          halt_req,
`ifdef PIPE_CTRL_STEP_EN
   input  logic          step,
`endif
   pipe_ctrl_if.master   bus,
   output logic          busy,
   output logic          halted,
   output logic [CW-1:0] cycle_cnt,
   output logic [CW-1:0] stall_cnt
);

   typedef enum logic [2:0] {IDLE, RUN, STALL, DRAIN, HALT} state_t;

   state_t         state, next_state;
   logic [2:0]     hold, next_hold;
   logic [RAW-1:0] rs1, rs2, rd;
   logic           hazard;
   logic           pc_c, ifid_c, flush_c, bub_c;
   logic           clr_cnt;
   logic           step_pulse;

   assign rs1 = bus.id_rs1;
   assign rs2 = bus.id_rs2;
   assign rd  = bus.ex_rd;

   // r0 is hardwired zero, so a write to it never creates a dependency.
   assign hazard = bus.ex_wen && (rd != '0) &&
                   ((bus.id_use1 && (rs1 == rd)) || (bus.id_use2 && (rs2 == rd)));

   always_comb begin
      next_state = state;
      next_hold  = hold;
      pc_c       = 1'b0;
      ifid_c     = 1'b0;
      flush_c    = 1'b0;
      bub_c      = 1'b0;
      clr_cnt    = 1'b0;
      step_pulse = 1'b0;
      case (state)
         IDLE, HALT: begin
            if (start) begin
               flush_c    = 1'b1;
               clr_cnt    = 1'b1;
               next_state = RUN;
            end
`ifdef PIPE_CTRL_STEP_EN
            else if (state == HALT && step) begin
               pc_c       = 1'b1;
               ifid_c     = 1'b1;
               step_pulse = 1'b1;
            end
`endif
         end
         RUN, STALL: begin
            if (halt_req) begin
               // First drain cycle: flush IF/ID and bubble EX, PC frozen.
               ifid_c  = 1'b1;
               flush_c = 1'b1;
               bub_c   = 1'b1;
               if (DRAIN_CYC == 1) begin
                  next_state = HALT;
                  next_hold  = 3'd0;
               end else begin
                  next_state = DRAIN;
                  next_hold  = 3'(DRAIN_CYC - 1);
               end
            end else if (state == RUN) begin
               if (hazard) begin
                  bub_c = 1'b1;
                  if (STALL_CYC > 1) begin
                     next_state = STALL;
                     next_hold  = 3'(STALL_CYC - 1);
                  end
               end else begin
                  pc_c   = 1'b1;
                  ifid_c = 1'b1;
               end
            end else begin
               bub_c = 1'b1;
               if (hold <= 3'd1) begin
                  next_state = RUN;
                  next_hold  = 3'd0;
               end else begin
                  next_hold = hold - 3'd1;
               end
            end
         end
         DRAIN: begin
            ifid_c  = 1'b1;
            flush_c = 1'b1;
            bub_c   = 1'b1;
            if (hold <= 3'd1) begin
               next_state = HALT;
               next_hold  = 3'd0;
            end else begin
               next_hold = hold - 3'd1;
            end
         end
         default: begin
            next_state = IDLE;
            next_hold  = 3'd0;
         end
      endcase
   end

   // Gate with rst so start seen during reset cannot leak a flush pulse.
   assign bus.pc_en      = rst & pc_c;
   assign bus.ifid_en    = rst & ifid_c;
   assign bus.ifid_flush = rst & flush_c;
   assign bus.ex_bubble  = rst & bub_c;

   assign busy   = (state == RUN) || (state == STALL) || (state == DRAIN);
   assign halted = (state == HALT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         hold      <= 3'd0;
         cycle_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         state <= next_state;
         hold  <= next_hold;
         if (clr_cnt) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
         end else begin
            if ((busy || step_pulse) && (cycle_cnt != '1))
               cycle_cnt <= cycle_cnt + 1'b1;
            // Drain bubbles are not stalls; the halt-request cycle itself is.
            if (bub_c && (state != DRAIN) && (stall_cnt != '1))
               stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed bench for pipe_ctrl. A second instance with CW=4
// shares all stimulus to exercise counter saturation.
// ctl vector order: {pc_en, ifid_en, ifid_flush, ex_bubble, busy, halted}
module tb_pipe_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       halt_req = 1'b0;
   logic       step = 1'b0;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic       use1 = 1'b0, use2 = 1'b0, wen = 1'b0;
   int         checks = 0;
   int         errors = 0;

   logic        busy, halted, busy4, halted4;
   logic [15:0] cycle_cnt, stall_cnt;
   logic [3:0]  cycle_cnt4, stall_cnt4;
   logic [5:0]  ctl;

   always #5 clk = ~clk;

   pipe_ctrl_if #(.RAW(5)) bus ();
   pipe_ctrl_if #(.RAW(5)) bus4 ();

   assign bus.id_rs1  = rs1;  assign bus4.id_rs1  = rs1;
   assign bus.id_rs2  = rs2;  assign bus4.id_rs2  = rs2;
   assign bus.id_use1 = use1; assign bus4.id_use1 = use1;
   assign bus.id_use2 = use2; assign bus4.id_use2 = use2;
   assign bus.ex_rd   = rd;   assign bus4.ex_rd   = rd;
   assign bus.ex_wen  = wen;  assign bus4.ex_wen  = wen;

   assign ctl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.ex_bubble, busy, halted};

   pipe_ctrl #(.RAW(5), .CW(16), .STALL_CYC(2), .DRAIN_CYC(3)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
`ifdef PIPE_CTRL_STEP_EN
      .step(step),
`endif
      .bus(bus), .busy(busy), .halted(halted),
      .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
   );

   pipe_ctrl #(.RAW(5), .CW(4), .STALL_CYC(2), .DRAIN_CYC(3)) dut4 (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
`ifdef PIPE_CTRL_STEP_EN
      .step(step),
`endif
      .bus(bus4), .busy(busy4), .halted(halted4),
      .cycle_cnt(cycle_cnt4), .stall_cnt(stall_cnt4)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      start = 1'b1;
      #1;
      checks++;
      if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl, 6'b000000); end
      checks++;
      if (cycle_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cycle_cnt, stall_cnt);
      end
      start = 1'b0;
      cyc();
      rst = 1'b1;
      #1;
      checks++;
      if (ctl !== 6'b000000) begin errors++; $display("FAIL idle_ctl got %b want %b", ctl, 6'b000000); end
   endtask

   task automatic test_start();
      start = 1'b1;
      #1;
      checks++;
      if (ctl !== 6'b001000) begin errors++; $display("FAIL start_flush got %b want %b", ctl, 6'b001000); end
      cyc();
      start = 1'b0;
      #1;
      checks++;
      if (ctl !== 6'b110010) begin errors++; $display("FAIL run_ctl got %b want %b", ctl, 6'b110010); end
      checks++;
      if (cycle_cnt !== 16'd0) begin errors++; $display("FAIL start_cnt got %0d want 0", cycle_cnt); end
      cyc();
      checks++;
      if (cycle_cnt !== 16'd1) begin errors++; $display("FAIL run_cnt got %0d want 1", cycle_cnt); end
   endtask

   task automatic test_no_hazard();
      // rd==0 with match, wen==0 with match, use1==0 with match
      logic [4:0] v_rs1 [3] = '{5'd0, 5'd3, 5'd3};
      logic [4:0] v_rd  [3] = '{5'd0, 5'd3, 5'd3};
      logic       v_wen [3] = '{1'b1, 1'b0, 1'b1};
      logic       v_use [3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         rs1 = v_rs1[i]; rd = v_rd[i]; wen = v_wen[i]; use1 = v_use[i];
         #1;
         checks++;
         if (ctl !== 6'b110010) begin errors++; $display("FAIL nohaz_%0d got %b want %b", i, ctl, 6'b110010); end
         cyc();
      end
      checks++;
      if (stall_cnt !== 16'd0 || cycle_cnt !== 16'd4) begin
         errors++; $display("FAIL nohaz_cnt got %0d/%0d want 4/0", cycle_cnt, stall_cnt);
      end
   endtask

   task automatic test_hazard();
      rs1 = 5'd3; use1 = 1'b1; rd = 5'd3; wen = 1'b1;
      #1;
      checks++;
      if (ctl !== 6'b000110) begin errors++; $display("FAIL haz_c1 got %b want %b", ctl, 6'b000110); end
      cyc();
      checks++;
      if (ctl !== 6'b000110) begin errors++; $display("FAIL haz_c2 got %b want %b", ctl, 6'b000110); end
      cyc();
      use1 = 1'b0; wen = 1'b0;
      #1;
      checks++;
      if (ctl !== 6'b110010) begin errors++; $display("FAIL haz_resume got %b want %b", ctl, 6'b110010); end
      checks++;
      if (stall_cnt !== 16'd2 || cycle_cnt !== 16'd6) begin
         errors++; $display("FAIL haz_cnt got %0d/%0d want 6/2", cycle_cnt, stall_cnt);
      end
      cyc();
   endtask

   task automatic test_halt_stall();
      rs2 = 5'd7; use2 = 1'b1; rd = 5'd7; wen = 1'b1;
      #1;
      checks++;
      if (ctl !== 6'b000110) begin errors++; $display("FAIL haz2 got %b want %b", ctl, 6'b000110); end
      cyc();
      halt_req = 1'b1;
      #1;
      checks++;
      if (ctl !== 6'b011110) begin errors++; $display("FAIL halt_c1 got %b want %b", ctl, 6'b011110); end
      cyc();
      halt_req = 1'b0; start = 1'b1;
      #1;
      checks++;
      if (ctl !== 6'b011110) begin errors++; $display("FAIL drain_c2 got %b want %b", ctl, 6'b011110); end
      cyc();
      checks++;
      if (ctl !== 6'b011110) begin errors++; $display("FAIL drain_c3 got %b want %b", ctl, 6'b011110); end
      start = 1'b0;
      cyc();
      use2 = 1'b0; wen = 1'b0;
      #1;
      checks++;
      if (ctl !== 6'b000001) begin errors++; $display("FAIL halted got %b want %b", ctl, 6'b000001); end
      checks++;
      if (cycle_cnt !== 16'd11 || stall_cnt !== 16'd4) begin
         errors++; $display("FAIL halt_cnt got %0d/%0d want 11/4", cycle_cnt, stall_cnt);
      end
      cyc();
      checks++;
      if (cycle_cnt !== 16'd11) begin errors++; $display("FAIL frozen got %0d want 11", cycle_cnt); end
   endtask

   task automatic test_reset_drain();
      start = 1'b1;
      #1;
      checks++;
      if (ctl !== 6'b001001) begin errors++; $display("FAIL restart got %b want %b", ctl, 6'b001001); end
      cyc();
      start = 1'b0; halt_req = 1'b1;
      #1;
      checks++;
      if (cycle_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
         errors++; $display("FAIL restart_clr got %0d/%0d want 0/0", cycle_cnt, stall_cnt);
      end
      cyc();
      halt_req = 1'b0;
      #1;
      checks++;
      if (ctl !== 6'b011110) begin errors++; $display("FAIL pre_rst got %b want %b", ctl, 6'b011110); end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (ctl !== 6'b000000 || cycle_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
         errors++; $display("FAIL async_rst got %b %0d/%0d want 000000 0/0", ctl, cycle_cnt, stall_cnt);
      end
      cyc();
      rst = 1'b1;
      cyc();
      checks++;
      if (ctl !== 6'b000000) begin errors++; $display("FAIL post_rst got %b want %b", ctl, 6'b000000); end
      start = 1'b1;
      #1;
      checks++;
      if (ctl !== 6'b001000) begin errors++; $display("FAIL rst_start got %b want %b", ctl, 6'b001000); end
      cyc();
      start = 1'b0;
      #1;
      checks++;
      if (ctl !== 6'b110010) begin errors++; $display("FAIL rst_run got %b want %b", ctl, 6'b110010); end
      cyc();
   endtask

   task automatic test_saturate();
      // one RUN cycle already counted; 19 more gives 20
      for (int i = 0; i < 19; i++) cyc();
      checks++;
      if (cycle_cnt !== 16'd20) begin errors++; $display("FAIL cnt16 got %0d want 20", cycle_cnt); end
      checks++;
      if (cycle_cnt4 !== 4'd15) begin errors++; $display("FAIL cnt4_sat got %0d want 15", cycle_cnt4); end
   endtask

   task automatic test_step();
      halt_req = 1'b1;
      cyc();
      halt_req = 1'b0;
      cyc();
      cyc();
      checks++;
      if (ctl !== 6'b000001 || cycle_cnt !== 16'd23) begin
         errors++; $display("FAIL step_halt got %b %0d want 000001 23", ctl, cycle_cnt);
      end
`ifdef PIPE_CTRL_STEP_EN
      step = 1'b1; start = 1'b1;
      #1;
      checks++;
      if (ctl !== 6'b001001) begin errors++; $display("FAIL step_prio got %b want %b", ctl, 6'b001001); end
      start = 1'b0;
      #1;
      checks++;
      if (ctl !== 6'b110001) begin errors++; $display("FAIL step_pulse got %b want %b", ctl, 6'b110001); end
      cyc();
      step = 1'b0;
      #1;
      checks++;
      if (ctl !== 6'b000001 || cycle_cnt !== 16'd24 || cycle_cnt4 !== 4'd15) begin
         errors++; $display("FAIL step_after got %b %0d/%0d want 000001 24/15", ctl, cycle_cnt, cycle_cnt4);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_start();
      test_no_hazard();
      test_hazard();
      test_halt_stall();
      test_reset_drain();
      test_saturate();
      test_step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
